dot_vector_loader: RTL and testbench



---
 rtl/dot_product_pkg.sv | 17 +
 rtl/dot_vector_loader.sv | 91 +++++++++
 tb/tb_dot_vector_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_pkg.sv
// rtl/dot_product_pkg.sv - shared types and sizing helpers for the dot-product vector loader
package dot_product_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int vec_width(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/dot_vector_loader.sv
// rtl/dot_vector_loader.sv - assembles serial (a_i, b_i) pairs into packed vectors for dot_product
module dot_vector_loader
    import dot_product_pkg::*;
#(
    parameter int num_elems  = 5,
    parameter int data_width = 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [data_width-1:0]                in_a,
    input  logic [data_width-1:0]                in_b,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [vec_width(num_elems, data_width)-1:0] out_a,
    output logic [vec_width(num_elems, data_width)-1:0] out_b,
    output logic                                 out_err
);

    localparam int cw = cnt_width(num_elems);
    localparam int vw = vec_width(num_elems, data_width);
    localparam logic [cw-1:0] last_idx = cw'(num_elems - 1);

    loader_state_t   state, state_next;
    logic [cw-1:0]   count, count_next;
    logic [vw-1:0]   a_next, b_next;
    logic            err_next;
    logic [cw-1:0]   lane;
    logic            accept;
    logic            at_last_lane;

    // A vector waiting in FULL always restarts at lane 0 when it is replaced.
    always_comb begin
        in_ready     = (state == LOAD) || out_ready;
        out_valid    = (state == FULL);
        accept       = in_valid && in_ready;
        lane         = (state == FULL) ? '0 : count;
        at_last_lane = (lane == last_idx);
    end

    always_comb begin
        state_next = state;
        count_next = count;
        a_next     = out_a;
        b_next     = out_b;
        err_next   = out_err;

        if (accept) begin
            // Writing lane 0 wipes the rest so short vectors read zero in unused lanes.
            for (int i = 0; i < num_elems; i++) begin
                if (lane == cw'(i)) begin
                    a_next[i*data_width +: data_width] = in_a;
                    b_next[i*data_width +: data_width] = in_b;
                end else if (lane == '0) begin
                    a_next[i*data_width +: data_width] = '0;
                    b_next[i*data_width +: data_width] = '0;
                end
            end

            if (in_last || at_last_lane) begin
                state_next = FULL;
                count_next = '0;
                err_next   = !(in_last && at_last_lane);
            end else begin
                state_next = LOAD;
                count_next = lane + 1'b1;
            end
        end else if (state == FULL && out_ready) begin
            state_next = LOAD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= LOAD;
            count   <= '0;
            out_a   <= '0;
            out_b   <= '0;
            out_err <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            out_a   <= a_next;
            out_b   <= b_next;
            out_err <= err_next;
        end
    end

endmodule

// File: tb/tb_dot_vector_loader.sv
// tb/tb_dot_vector_loader.sv - self-checking bench for dot_vector_loader with a queue-based framing model
module tb_dot_vector_loader;

    localparam int N  = 5;
    localparam int W  = 2;
    localparam int VW = N * W;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_last;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid, out_ready, out_err;
    logic [VW-1:0] out_a, out_b;

    dot_vector_loader #(.num_elems(N), .data_width(W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_err(out_err)
    );

    always #5 clock = ~clock;

    typedef struct { logic [VW-1:0] a; logic [VW-1:0] b; logic err; } vec_t;
    typedef struct { logic valid; logic rdy; logic err; logic [VW-1:0] a; logic [VW-1:0] b; } obs_t;

    vec_t         exp_q[$];
    logic [W-1:0] pa[$];
    logic [W-1:0] pb[$];
    int           checks = 0;
    int           errors = 0;

    task automatic model_reset();
        exp_q.delete(); pa.delete(); pb.delete();
    endtask

    // Frame closes on in_last or on the Nth element; error unless both coincide.
    task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        vec_t v;
        pa.push_back(a); pb.push_back(b);
        if (last || pa.size() == N) begin
            v.a = '0; v.b = '0;
            for (int i = 0; i < pa.size(); i++) begin
                v.a[i*W +: W] = pa[i];
                v.b[i*W +: W] = pb[i];
            end
            v.err = !(last && pa.size() == N);
            exp_q.push_back(v);
            pa.delete(); pb.delete();
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic last, input logic ordy,
                         output obs_t o, output bit has, output vec_t front, output bit exp_rdy);
        in_valid = v; in_a = a; in_b = b; in_last = last; out_ready = ordy;
        #1;
        o.valid = out_valid; o.rdy = in_ready; o.err = out_err; o.a = out_a; o.b = out_b;
        has = (exp_q.size() != 0);
        if (has) front = exp_q[0];
        else begin front.a = '0; front.b = '0; front.err = 1'b0; end
        exp_rdy = !has || ordy;
        @(posedge clock); #2;
        if (has && ordy) exp_q.delete(0);
        if (v && exp_rdy) model_accept(a, b, last);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_last = 0; out_ready = 0;
        repeat (2) @(posedge clock);
        #2;
        checks++;
        if ({out_valid, out_err, out_a, out_b} !== '0)
            begin errors++; $display("FAIL reset_outputs: got v=%b e=%b a=%h b=%h expected all 0", out_valid, out_err, out_a, out_b); end
        reset = 1'b0;
        model_reset();
        @(posedge clock); #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_nominal();
        logic [W-1:0] va[N];
        obs_t o; bit has, er; vec_t f;
        va = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, va[i], 2'b01, i == N-1, 1'b1, o, has, f, er);
            checks++;
            if (o.rdy !== 1'b1 || o.valid !== 1'b0)
                begin errors++; $display("FAIL nominal_load[%0d]: got rdy=%b valid=%b expected 1/0", i, o.rdy, o.valid); end
        end
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, o, has, f, er);
        checks++;
        if (o.valid !== 1'b1 || o.a !== 10'h24D || o.b !== 10'h155 || o.err !== 1'b0)
            begin errors++; $display("FAIL nominal_out: got v=%b a=%h b=%h e=%b expected 1 24d 155 0", o.valid, o.a, o.b, o.err); end
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, o, has, f, er);
        checks++;
        if (o.valid !== 1'b0)
            begin errors++; $display("FAIL nominal_consumed: got valid=%b expected 0", o.valid); end
    endtask

    task automatic test_short();
        obs_t o; bit has, er; vec_t f;
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b01, 2'b11, i == 2, 1'b1, o, has, f, er);
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, o, has, f, er);
        checks++;
        if (o.valid !== 1'b1 || o.a !== 10'h015 || o.b !== 10'h03F || o.err !== 1'b1)
            begin errors++; $display("FAIL short_out: got v=%b a=%h b=%h e=%b expected 1 015 03f 1", o.valid, o.a, o.b, o.err); end
    endtask

    task automatic test_long();
        obs_t o; bit has, er; vec_t f;
        logic [W-1:0] rb;
        for (int i = 0; i < N; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, o, has, f, er);
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, o, has, f, er);
        checks++;
        if (o.valid !== 1'b1 || o.err !== 1'b1 || o.a !== f.a || o.b !== f.b)
            begin errors++; $display("FAIL long_out: got v=%b e=%b a=%h b=%h expected 1 1 %h %h", o.valid, o.err, o.a, o.b, f.a, f.b); end
        for (int i = 0; i < N; i++) begin
            rb = W'($urandom);
            cycle(1'b1, (i == 0) ? 2'b01 : 2'b00, rb, i == N-1, 1'b1, o, has, f, er);
        end
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, o, has, f, er);
        checks++;
        if (o.valid !== 1'b1 || o.a !== 10'h001 || o.err !== 1'b0 || o.b !== f.b)
            begin errors++; $display("FAIL long_resume: got v=%b a=%h e=%b b=%h expected 1 001 0 %h", o.valid, o.a, o.err, o.b, f.b); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] va[N];
        obs_t o; bit has, er; vec_t f;
        va = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < N; i++) cycle(1'b1, va[i], 2'b01, i == N-1, 1'b1, o, has, f, er);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 2'b11, 2'b10, 1'b0, 1'b0, o, has, f, er);
            checks++;
            if (o.rdy !== 1'b0 || o.valid !== 1'b1 || o.a !== 10'h24D || o.b !== 10'h155 || o.err !== 1'b0)
                begin errors++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b a=%h b=%h e=%b expected 0 1 24d 155 0", k, o.rdy, o.valid, o.a, o.b, o.err); end
        end
        cycle(1'b1, 2'b11, 2'b10, 1'b0, 1'b1, o, has, f, er);
        checks++;
        if (o.rdy !== 1'b1 || o.valid !== 1'b1)
            begin errors++; $display("FAIL bp_release: got rdy=%b v=%b expected 1 1", o.rdy, o.valid); end
        for (int i = 1; i < N; i++) begin
            cycle(1'b1, 2'b01, 2'b01, i == N-1, 1'b1, o, has, f, er);
            if (i == 1) begin
                checks++;
                if (o.valid !== 1'b0 || o.a !== 10'h003 || o.b !== 10'h002)
                    begin errors++; $display("FAIL bp_lane0: got v=%b a=%h b=%h expected 0 003 002", o.valid, o.a, o.b); end
            end
        end
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, o, has, f, er);
        checks++;
        if (o.valid !== 1'b1 || o.a !== 10'h157 || o.b !== 10'h156 || o.err !== 1'b0)
            begin errors++; $display("FAIL bp_next_vec: got v=%b a=%h b=%h e=%b expected 1 157 156 0", o.valid, o.a, o.b, o.err); end
    endtask

    task automatic test_back_to_back();
        obs_t o; bit has, er; vec_t f;
        for (int k = 0; k < 12; k++) begin
            cycle(k < 2*N, W'($urandom), W'($urandom), (k == N-1) || (k == 2*N-1), 1'b1, o, has, f, er);
            checks++;
            if (o.valid !== (k == N || k == 2*N) || o.rdy !== 1'b1)
                begin errors++; $display("FAIL b2b_valid[%0d]: got v=%b rdy=%b expected %b 1", k, o.valid, o.rdy, (k == N || k == 2*N)); end
            if (has) begin
                checks++;
                if (o.a !== f.a || o.b !== f.b || o.err !== f.err)
                    begin errors++; $display("FAIL b2b_data[%0d]: got a=%h b=%h e=%b expected %h %h %b", k, o.a, o.b, o.err, f.a, f.b, f.err); end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; bit has, er; vec_t f;
        for (int i = 0; i < 2; i++) cycle(1'b1, 2'b11, 2'b11, 1'b0, 1'b1, o, has, f, er);
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_err, out_a, out_b} !== '0)
            begin errors++; $display("FAIL reset_mid_async: got v=%b e=%b a=%h b=%h expected all 0", out_valid, out_err, out_a, out_b); end
        #2;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) cycle(1'b1, 2'b11, 2'b11, i == N-1, 1'b1, o, has, f, er);
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, o, has, f, er);
        checks++;
        if (o.valid !== 1'b1 || o.a !== 10'h3FF || o.b !== 10'h3FF || o.err !== 1'b0)
            begin errors++; $display("FAIL reset_mid_next: got v=%b a=%h b=%h e=%b expected 1 3ff 3ff 0", o.valid, o.a, o.b, o.err); end
    endtask

    task automatic test_random();
        obs_t o; bit has, er; vec_t f;
        logic v, ordy;
        for (int k = 0; k < 400; k++) begin
            v    = ($urandom_range(3) != 0);
            ordy = ($urandom_range(2) != 0);
            cycle(v, W'($urandom), W'($urandom), $urandom_range(4) == 0, ordy, o, has, f, er);
            checks++;
            if (o.valid !== has || o.rdy !== er)
                begin errors++; $display("FAIL rand_hs[%0d]: got v=%b rdy=%b expected %b %b", k, o.valid, o.rdy, has, er); end
            if (has) begin
                checks++;
                if (o.a !== f.a || o.b !== f.b || o.err !== f.err)
                    begin errors++; $display("FAIL rand_data[%0d]: got a=%h b=%h e=%b expected %h %h %b", k, o.a, o.b, o.err, f.a, f.b, f.err); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_long();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
